// File: rtl/score_lives_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_lives_keeper
//  Purpose  : Pinball game bookkeeping. Keeps a 4-digit BCD score, the number
//             of remaining balls, and the IDLE/PLAY/RESPAWN/GAME_OVER game
//             state machine with a frame-counted respawn delay.
//  Ports    : clk          - system clock
//             resetN       - asynchronous active-low reset
//             startOfFrame - one-cycle pulse per video frame
//             startGame    - new game request (honoured in IDLE/GAME_OVER)
//             bumperHit    - one-cycle bumper collision pulse
//             targetHit    - one-cycle target collision pulse
//             ballLost     - one-cycle pulse when the ball leaves the field
//             score        - 4 BCD digits, thousands in [15:12]
//             lives        - remaining balls
//             ballEnable   - high only in PLAY
//             gameOver     - high only in GAME_OVER
//             state        - FSM state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module score_lives_keeper #(
  parameter int BUMPER_POINTS  = 5,
  parameter int TARGET_POINTS  = 20,
  parameter int INITIAL_LIVES  = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        bumperHit,
  input  logic        targetHit,
  input  logic        ballLost,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        ballEnable,
  output logic        gameOver,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    RESPAWN   = 2'b10,
    GAME_OVER = 2'b11
  } state_t;

  // Binary-to-BCD conversion, evaluated only on constants at elaboration.
  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10),   4'(v % 10)};
  endfunction

  // Digit-serial BCD addition; a carry out of the thousands digit means the
  // true sum exceeds 9999, so the result pins at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                              input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      s = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*d +: 4] = s[3:0];
    end
    bcd_add_sat = c ? 16'h9999 : r;
  endfunction

  localparam logic [15:0] BUMPER_BCD = to_bcd(BUMPER_POINTS);
  localparam logic [15:0] TARGET_BCD = to_bcd(TARGET_POINTS);
  localparam logic [15:0] BOTH_BCD   = to_bcd(BUMPER_POINTS + TARGET_POINTS);
  localparam logic [2:0]  LIVES_INIT = 3'(INITIAL_LIVES);
  localparam logic [7:0]  FRAMES_INIT = 8'(RESPAWN_FRAMES);

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  frame_q, frame_d;
  logic        ball_en_q;
  logic        game_over_q;
  logic [15:0] pts;
  logic        any_hit;

  // Simultaneous hits are folded into one precomputed constant so a single
  // adder pass handles every case.
  always_comb begin
    pts     = 16'h0000;
    any_hit = bumperHit | targetHit;
    case ({bumperHit, targetHit})
      2'b10:   pts = BUMPER_BCD;
      2'b01:   pts = TARGET_BCD;
      2'b11:   pts = BOTH_BCD;
      default: pts = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    frame_d = frame_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (startGame) begin
          state_d = PLAY;
          score_d = 16'h0000;
          lives_d = LIVES_INIT;
          frame_d = 8'd0;
        end
      end
      PLAY: begin
        if (any_hit) begin
          score_d = bcd_add_sat(score_q, pts);
        end
        if (ballLost) begin
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          if (lives_q > 3'd1) begin
            state_d = RESPAWN;
            frame_d = FRAMES_INIT;
          end else begin
            state_d = GAME_OVER;
          end
        end
      end
      RESPAWN: begin
        // The pulse that takes the counter to zero also re-enters PLAY, so
        // the ball is hidden for exactly RESPAWN_FRAMES frame pulses.
        if (startOfFrame) begin
          if (frame_q <= 8'd1) begin
            frame_d = 8'd0;
            state_d = PLAY;
          end else begin
            frame_d = frame_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      score_q     <= 16'h0000;
      lives_q     <= LIVES_INIT;
      frame_q     <= 8'd0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      frame_q     <= frame_d;
      ball_en_q   <= (state_d == PLAY);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  assign score      = score_q;
  assign lives      = lives_q;
  assign ballEnable = ball_en_q;
  assign gameOver   = game_over_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_score_lives_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_lives_keeper
//  Purpose  : Directed self-checking bench for score_lives_keeper with
//             hand-computed expected values (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_lives_keeper;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        startGame;
  logic        bumperHit;
  logic        targetHit;
  logic        ballLost;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        ballEnable;
  logic        gameOver;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  score_lives_keeper dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .bumperHit    (bumperHit),
    .targetHit    (targetHit),
    .ballLost     (ballLost),
    .score        (score),
    .lives        (lives),
    .ballEnable   (ballEnable),
    .gameOver     (gameOver),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st,
                           input logic [15:0] sc, input logic [2:0] lv,
                           input logic be, input logic go);
    check({tag, ".state"},      {14'b0, state},      {14'b0, st});
    check({tag, ".score"},      score,               sc);
    check({tag, ".lives"},      {13'b0, lives},      {13'b0, lv});
    check({tag, ".ballEnable"}, {15'b0, ballEnable}, {15'b0, be});
    check({tag, ".gameOver"},   {15'b0, gameOver},   {15'b0, go});
  endtask

  task automatic pulse_start();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
  endtask

  // Runs a full respawn; disturbs the block mid-way with ignored inputs.
  task automatic run_respawn(input string tag, input logic [15:0] sc,
                             input logic [2:0] lv);
    for (int i = 0; i < 60; i++) begin
      check_all(tag, 2'b10, sc, lv, 1'b0, 1'b0);
      if (i == 5) begin
        ballLost  = 1'b1;
        bumperHit = 1'b1;
        targetHit = 1'b1;
        startGame = 1'b1;
        tick();
        ballLost  = 1'b0;
        bumperHit = 1'b0;
        targetHit = 1'b0;
        startGame = 1'b0;
        tick();
        check_all({tag, ".ignored"}, 2'b10, sc, lv, 1'b0, 1'b0);
      end
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (i < 59) tick();
    end
    check_all({tag, ".back"}, 2'b01, sc, lv, 1'b1, 1'b0);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    startGame    = 1'b0;
    bumperHit    = 1'b0;
    targetHit    = 1'b0;
    ballLost     = 1'b0;
    tick();
    tick();
    check_all("reset", 2'b00, 16'h0000, 3'd3, 1'b0, 1'b0);
    resetN = 1'b1;
    tick();
    bumperHit = 1'b1;
    ballLost  = 1'b1;
    tick();
    bumperHit = 1'b0;
    ballLost  = 1'b0;
    tick();
    check_all("idle_hold", 2'b00, 16'h0000, 3'd3, 1'b0, 1'b0);

    pulse_start();
    check_all("start", 2'b01, 16'h0000, 3'd3, 1'b1, 1'b0);

    bumperHit = 1'b1;
    tick();
    check("bump1", score, 16'h0005);
    tick();
    check("bump2", score, 16'h0010);
    tick();
    bumperHit = 1'b0;
    check("bump3", score, 16'h0015);
    bumperHit = 1'b1;
    targetHit = 1'b1;
    tick();
    bumperHit = 1'b0;
    targetHit = 1'b0;
    check("both", score, 16'h0040);
    tick();
    check("both_hold", score, 16'h0040);

    ballLost = 1'b1;
    tick();
    ballLost = 1'b0;
    check_all("lost3", 2'b10, 16'h0040, 3'd2, 1'b0, 1'b0);
    run_respawn("resp1", 16'h0040, 3'd2);

    // Hit coinciding with the loss is still scored.
    ballLost  = 1'b1;
    bumperHit = 1'b1;
    tick();
    ballLost  = 1'b0;
    bumperHit = 1'b0;
    check_all("lost2", 2'b10, 16'h0045, 3'd1, 1'b0, 1'b0);
    run_respawn("resp2", 16'h0045, 3'd1);

    ballLost = 1'b1;
    tick();
    ballLost = 1'b0;
    check_all("over", 2'b11, 16'h0045, 3'd0, 1'b0, 1'b1);
    bumperHit = 1'b1;
    targetHit = 1'b1;
    ballLost  = 1'b1;
    tick();
    bumperHit = 1'b0;
    targetHit = 1'b0;
    ballLost  = 1'b0;
    tick();
    check_all("over_hold", 2'b11, 16'h0045, 3'd0, 1'b0, 1'b1);

    pulse_start();
    check_all("restart", 2'b01, 16'h0000, 3'd3, 1'b1, 1'b0);

    targetHit = 1'b1;
    for (int i = 0; i < 499; i++) tick();
    check("tgt499", score, 16'h9980);
    tick();
    targetHit = 1'b0;
    check("tgt500", score, 16'h9999);
    bumperHit = 1'b1;
    tick();
    bumperHit = 1'b0;
    check("sat_bump", score, 16'h9999);

    ballLost = 1'b1;
    tick();
    ballLost = 1'b0;
    check_all("lost_sat", 2'b10, 16'h9999, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
    check({14'b0, state} == 16'h0002 ? "mid_resp" : "mid_resp", {14'b0, state}, 16'h0002);
    #2;
    resetN = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 16'h0000, 3'd3, 1'b0, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    tick();
    check_all("post_rst", 2'b00, 16'h0000, 3'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
